// File: rtl/bp_sacc_pkg.sv
// Shared types and constants for the accelerator scratchpad arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bp_sacc_pkg;

    // Which requester a registered SPM read response belongs to.
    typedef enum logic {
        e_owner_eng = 1'b0,
        e_owner_ext = 1'b1
    } spm_owner_e;

    // Byte address to 64-bit word index.
    localparam int word_shift_lp = 3;

endpackage

// File: rtl/bp_sacc_spm_resp_buf.sv
// One-entry data+error holding buffer for external SPM read responses.
// Latency: loaded data visible the cycle after load_i.
// Backpressure: contents held until yumi_i; a load in the yumi cycle replaces the old entry.
//
// Ports: clk_i/reset_i (async active-high), load_i/data_i/err_i fill the entry,
//        v_o/data_o/err_o present it, yumi_i consumes it.
module bp_sacc_spm_resp_buf #(
    parameter int data_width_p = 64
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    load_i,
    input  logic [data_width_p-1:0] data_i,
    input  logic                    err_i,
    output logic                    v_o,
    output logic [data_width_p-1:0] data_o,
    output logic                    err_o,
    input  logic                    yumi_i
);

    logic                    v_q;
    logic [data_width_p-1:0] data_q;
    logic                    err_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            v_q    <= 1'b0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else if (load_i) begin
            v_q    <= 1'b1;
            data_q <= data_i;
            err_q  <= err_i;
        end else if (yumi_i) begin
            v_q    <= 1'b0;
            err_q  <= 1'b0;
        end
    end

    assign v_o    = v_q;
    assign data_o = data_q;
    assign err_o  = v_q & err_q;

endmodule

// File: rtl/bp_sacc_spm_arbiter.sv
// Arbitrates the single 1rw-sync scratchpad between external I/O and the vector engine.
// Latency: SPM driven in the grant cycle; engine data 1 cycle later, external buffer valid 2 cycles later.
// Backpressure: external reads stall (ext_ready_o=0) while a response is in flight or the buffer is unconsumed.
//
// Ports: clk_i, reset_i (async active-high); ext_* external request / buffered response (valid-yumi);
//        eng_* engine request / one-cycle read pulse; spm_* to the bsg_mem_1rw_sync kept outside.
// Optional: define BP_SACC_SPM_ARB_FAIRNESS_EN to bound consecutive external grants while the engine waits.
module bp_sacc_spm_arbiter
    import bp_sacc_pkg::*;
#(
    parameter int data_width_p   = 64,
    parameter int els_p          = 20,
    parameter int addr_width_p   = 39,
    parameter int starve_limit_p = 4,
    localparam int spm_addr_width_lp = $clog2(els_p)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,

    input  logic                         ext_v_i,
    input  logic                         ext_w_i,
    input  logic [addr_width_p-1:0]      ext_addr_i,
    input  logic [data_width_p-1:0]      ext_data_i,
    output logic                         ext_ready_o,
    output logic [data_width_p-1:0]      ext_rdata_o,
    output logic                         ext_rdata_v_o,
    input  logic                         ext_rdata_yumi_i,
    output logic                         ext_err_o,

    input  logic                         eng_v_i,
    input  logic                         eng_w_i,
    input  logic [addr_width_p-1:0]      eng_addr_i,
    input  logic [data_width_p-1:0]      eng_data_i,
    input  logic                         eng_lock_i,
    output logic                         eng_ready_o,
    output logic [data_width_p-1:0]      eng_rdata_o,
    output logic                         eng_rdata_v_o,

    output logic                         spm_v_o,
    output logic                         spm_w_o,
    output logic [spm_addr_width_lp-1:0] spm_addr_o,
    output logic [data_width_p-1:0]      spm_data_o,
    input  logic [data_width_p-1:0]      spm_data_i
);

    localparam int idx_width_lp = addr_width_p - word_shift_lp;
    localparam logic [idx_width_lp-1:0] els_idx_lp = idx_width_lp'(els_p);

    // Registered read-response tracking (one read in flight at most).
    logic       rd_v_q;
    spm_owner_e rd_owner_q;
    logic       rd_oor_q;

    logic ext_pend, buf_v, buf_can_take, ext_elig, grant_ext, eng_force, live;

    assign live     = ~reset_i;
    assign ext_pend = rd_v_q & (rd_owner_q == e_owner_ext);

    // The buffer must be free in the response cycle: no read already in flight,
    // and either empty now or being drained this cycle.
    assign buf_can_take = ~ext_pend & (~buf_v | ext_rdata_yumi_i);
    assign ext_elig     = ext_v_i & (ext_w_i | buf_can_take);

    // Default grant goes to the engine, so exactly one ready is high outside reset.
    assign grant_ext = ext_elig & ~(eng_v_i & (eng_lock_i | eng_force));

`ifdef BP_SACC_SPM_ARB_FAIRNESS_EN
    localparam int starve_width_lp = $clog2(starve_limit_p + 1);
    logic [starve_width_lp-1:0] starve_cnt_q;

    assign eng_force = (starve_cnt_q >= starve_width_lp'(starve_limit_p));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            starve_cnt_q <= '0;
        end else if (eng_v_i & ~grant_ext) begin
            starve_cnt_q <= '0;
        end else if (eng_v_i & grant_ext & ~eng_force) begin
            starve_cnt_q <= starve_cnt_q + 1'b1;
        end
    end
`else
    logic unused_starve_limit;
    assign unused_starve_limit = (starve_limit_p != 0);
    assign eng_force = 1'b0;
`endif

    // Selected request.
    logic                    sel_v, sel_w, in_range;
    logic [addr_width_p-1:0] sel_addr;
    logic [data_width_p-1:0] sel_data;
    logic [idx_width_lp-1:0] sel_idx;
    logic [word_shift_lp-1:0] unused_addr_lsbs;

    assign sel_v    = grant_ext ? ext_v_i    : eng_v_i;
    assign sel_w    = grant_ext ? ext_w_i    : eng_w_i;
    assign sel_addr = grant_ext ? ext_addr_i : eng_addr_i;
    assign sel_data = grant_ext ? ext_data_i : eng_data_i;

    assign sel_idx          = sel_addr[addr_width_p-1:word_shift_lp];
    assign unused_addr_lsbs = sel_addr[word_shift_lp-1:0];
    assign in_range         = (sel_idx < els_idx_lp);

    // Readies and SPM strobes fall with reset immediately, not at the next edge.
    assign ext_ready_o = live & grant_ext;
    assign eng_ready_o = live & ~grant_ext;

    // Out-of-range requests are accepted but never touch the SPM.
    assign spm_v_o    = live & sel_v & in_range;
    assign spm_w_o    = spm_v_o & sel_w;
    assign spm_addr_o = sel_idx[spm_addr_width_lp-1:0];
    assign spm_data_o = sel_data;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_v_q     <= 1'b0;
            rd_owner_q <= e_owner_eng;
            rd_oor_q   <= 1'b0;
        end else begin
            rd_v_q     <= sel_v & ~sel_w;
            rd_owner_q <= grant_ext ? e_owner_ext : e_owner_eng;
            rd_oor_q   <= ~in_range;
        end
    end

    logic [data_width_p-1:0] rdata;
    assign rdata = rd_oor_q ? '0 : spm_data_i;

    assign eng_rdata_v_o = rd_v_q & (rd_owner_q == e_owner_eng);
    assign eng_rdata_o   = rdata;

    bp_sacc_spm_resp_buf #(
        .data_width_p(data_width_p)
    ) resp_buf (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (ext_pend),
        .data_i  (rdata),
        .err_i   (rd_oor_q),
        .v_o     (buf_v),
        .data_o  (ext_rdata_o),
        .err_o   (ext_err_o),
        .yumi_i  (ext_rdata_yumi_i)
    );

    assign ext_rdata_v_o = buf_v;

endmodule

// File: tb/tb_bp_sacc_spm_arbiter.sv
module tb_bp_sacc_spm_arbiter;

    localparam int DW  = 64;
    localparam int ELS = 20;
    localparam int AW  = 39;

`ifdef BP_SACC_SPM_ARB_FAIRNESS_EN
    localparam bit FAIR_EN = 1'b1;
`else
    localparam bit FAIR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          ext_v, ext_w, ext_ready, ext_rdata_v, ext_yumi, ext_err;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_data, ext_rdata;
    logic          eng_v, eng_w, eng_lock, eng_ready, eng_rdata_v;
    logic [AW-1:0] eng_addr;
    logic [DW-1:0] eng_data, eng_rdata;
    logic          spm_v, spm_w;
    logic [4:0]    spm_addr;
    logic [DW-1:0] spm_wdata, spm_rdata;

    bp_sacc_spm_arbiter dut (
        .clk_i(clk), .reset_i(reset),
        .ext_v_i(ext_v), .ext_w_i(ext_w), .ext_addr_i(ext_addr), .ext_data_i(ext_data),
        .ext_ready_o(ext_ready), .ext_rdata_o(ext_rdata), .ext_rdata_v_o(ext_rdata_v),
        .ext_rdata_yumi_i(ext_yumi), .ext_err_o(ext_err),
        .eng_v_i(eng_v), .eng_w_i(eng_w), .eng_addr_i(eng_addr), .eng_data_i(eng_data),
        .eng_lock_i(eng_lock), .eng_ready_o(eng_ready), .eng_rdata_o(eng_rdata),
        .eng_rdata_v_o(eng_rdata_v),
        .spm_v_o(spm_v), .spm_w_o(spm_w), .spm_addr_o(spm_addr), .spm_data_o(spm_wdata),
        .spm_data_i(spm_rdata)
    );

    // Behavioural 1rw synchronous scratchpad.
    logic [DW-1:0] mem [ELS];
    always @(posedge clk) begin
        if (spm_v) begin
            if (spm_w) mem[spm_addr] <= spm_wdata;
            else       spm_rdata     <= mem[spm_addr];
        end
    end

    logic [DW-1:0] ref_mem [ELS];

    typedef struct packed {
        logic [DW-1:0] d;
        logic          e;
    } resp_t;

    resp_t         ext_q[$];
    logic [DW-1:0] eng_q[$];
    resp_t         m_ext_exp;
    logic [DW-1:0] m_eng_exp;

    int checks = 0;
    int errors = 0;

    // Scoreboard: engine pulses and consumed external responses pop expected values.
    always @(negedge clk) begin
        if (!reset && eng_rdata_v) begin
            checks++;
            if (eng_q.size() == 0) begin
                errors++;
                $display("FAIL eng_unexpected got=%0h exp=none", eng_rdata);
            end else begin
                m_eng_exp = eng_q.pop_front();
                if (eng_rdata !== m_eng_exp) begin
                    errors++;
                    $display("FAIL eng_rdata got=%0h exp=%0h", eng_rdata, m_eng_exp);
                end
            end
        end
        if (!reset && ext_rdata_v && ext_yumi) begin
            checks++;
            if (ext_q.size() == 0) begin
                errors++;
                $display("FAIL ext_unexpected got=%0h exp=none", ext_rdata);
            end else begin
                m_ext_exp = ext_q.pop_front();
                if ({ext_rdata, ext_err} !== {m_ext_exp.d, m_ext_exp.e}) begin
                    errors++;
                    $display("FAIL ext_rdata got=%0h/%0b exp=%0h/%0b",
                             ext_rdata, ext_err, m_ext_exp.d, m_ext_exp.e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic idle();
        ext_v = 0; ext_w = 0; eng_v = 0; eng_w = 0; eng_lock = 0;
    endtask

    // Waits (bounded) for external data, then consumes it with a one-cycle yumi.
    task automatic consume_ext(input string name);
        bit found = 0;
        for (int n = 0; n < 10 && !found; n++) begin
            at_neg();
            if (ext_rdata_v) found = 1;
            tick();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s_timeout got=0 exp=1", name);
        end else begin
            ext_yumi = 1;
            at_neg();
            tick();
            ext_yumi = 0;
        end
    endtask

    task automatic test_reset();
        at_neg();
        checks++;
        if ({ext_ready, eng_ready} !== 2'b00) begin
            errors++; $display("FAIL rst_ready got=%b exp=00", {ext_ready, eng_ready});
        end
        checks++;
        if ({spm_v, spm_w} !== 2'b00) begin
            errors++; $display("FAIL rst_spm got=%b exp=00", {spm_v, spm_w});
        end
        checks++;
        if ({ext_rdata_v, eng_rdata_v, ext_err} !== 3'b000) begin
            errors++; $display("FAIL rst_resp got=%b exp=000", {ext_rdata_v, eng_rdata_v, ext_err});
        end
        tick();
        reset = 0;
        at_neg();
        checks++;
        if ({eng_ready, ext_ready} !== 2'b10) begin
            errors++; $display("FAIL idle_grant got=%b exp=10", {eng_ready, ext_ready});
        end
        tick();
    endtask

    task automatic test_ext_wr_rd();
        ext_v = 1; ext_w = 1; ext_addr = 'h08; ext_data = 64'hDEAD;
        at_neg();
        checks++;
        if ({ext_ready, spm_v, spm_w, spm_addr} !== {3'b111, 5'd1}) begin
            errors++; $display("FAIL ext_wr got=%b exp=11100001", {ext_ready, spm_v, spm_w, spm_addr});
        end
        ref_mem[1] = 64'hDEAD;
        tick();
        ext_w = 0;
        at_neg();
        checks++;
        if (ext_ready !== 1'b1) begin
            errors++; $display("FAIL ext_rd_ready got=%b exp=1", ext_ready);
        end
        ext_q.push_back('{d: ref_mem[1], e: 1'b0});
        tick();
        idle();
        at_neg();
        checks++;
        if (ext_rdata_v !== 1'b0) begin
            errors++; $display("FAIL ext_rd_early got=%b exp=0", ext_rdata_v);
        end
        tick();
        at_neg();
        checks++;
        if (ext_rdata_v !== 1'b1) begin
            errors++; $display("FAIL ext_rd_lat2 got=%b exp=1", ext_rdata_v);
        end
        tick();
        consume_ext("ext_rd");
    endtask

    task automatic test_lock();
        eng_v = 1; eng_w = 1; eng_addr = 'h10; eng_data = 64'h1111; eng_lock = 1;
        ext_v = 1; ext_w = 0; ext_addr = 'h10;
        at_neg();
        checks++;
        if ({eng_ready, ext_ready} !== 2'b10) begin
            errors++; $display("FAIL lock_grant got=%b exp=10", {eng_ready, ext_ready});
        end
        ref_mem[2] = 64'h1111;
        tick();
        eng_v = 0; eng_lock = 0;
        at_neg();
        checks++;
        if (ext_ready !== 1'b1) begin
            errors++; $display("FAIL lock_ext_next got=%b exp=1", ext_ready);
        end
        ext_q.push_back('{d: ref_mem[2], e: 1'b0});
        tick();
        idle();
        consume_ext("lock_rd");
    endtask

    task automatic test_backpressure();
        ext_v = 1; ext_w = 0; ext_addr = 'h08;
        at_neg();
        checks++;
        if (ext_ready !== 1'b1) begin
            errors++; $display("FAIL bp_first got=%b exp=1", ext_ready);
        end
        ext_q.push_back('{d: ref_mem[1], e: 1'b0});
        tick();
        ext_addr = 'h10;
        for (int i = 0; i < 6; i++) begin
            at_neg();
            checks++;
            if ({ext_ready, eng_ready} !== 2'b01) begin
                errors++; $display("FAIL bp_stall%0d got=%b exp=01", i, {ext_ready, eng_ready});
            end
            tick();
        end
        ext_yumi = 1;
        at_neg();
        checks++;
        if ({ext_ready, ext_rdata_v} !== 2'b11) begin
            errors++; $display("FAIL bp_yumi_cycle got=%b exp=11", {ext_ready, ext_rdata_v});
        end
        ext_q.push_back('{d: ref_mem[2], e: 1'b0});
        tick();
        ext_yumi = 0;
        idle();
        consume_ext("bp_second");
    endtask

    task automatic test_eng_read();
        eng_v = 1; eng_w = 0; eng_addr = 'h08;
        at_neg();
        checks++;
        if ({eng_ready, spm_v, spm_w} !== 3'b110) begin
            errors++; $display("FAIL eng_rd_grant got=%b exp=110", {eng_ready, spm_v, spm_w});
        end
        eng_q.push_back(ref_mem[1]);
        tick();
        idle();
        at_neg();
        checks++;
        if (eng_rdata_v !== 1'b1) begin
            errors++; $display("FAIL eng_rd_pulse got=%b exp=1", eng_rdata_v);
        end
        tick();
        at_neg();
        checks++;
        if (eng_rdata_v !== 1'b0) begin
            errors++; $display("FAIL eng_rd_onecycle got=%b exp=0", eng_rdata_v);
        end
        tick();
    endtask

    task automatic test_range();
        // Last valid word (index 19).
        ext_v = 1; ext_w = 1; ext_addr = 'h98; ext_data = 64'h1919;
        at_neg();
        checks++;
        if ({ext_ready, spm_v, spm_addr} !== {2'b11, 5'd19}) begin
            errors++; $display("FAIL top_word got=%b exp=1110011", {ext_ready, spm_v, spm_addr});
        end
        ref_mem[19] = 64'h1919;
        tick();
        // First invalid word (index 20): write dropped.
        ext_addr = 'hA0; ext_data = 64'hBAD;
        at_neg();
        checks++;
        if ({ext_ready, spm_v} !== 2'b10) begin
            errors++; $display("FAIL oor_wr got=%b exp=10", {ext_ready, spm_v});
        end
        tick();
        ext_w = 0;
        at_neg();
        checks++;
        if ({ext_ready, spm_v} !== 2'b10) begin
            errors++; $display("FAIL oor_rd got=%b exp=10", {ext_ready, spm_v});
        end
        ext_q.push_back('{d: '0, e: 1'b1});
        tick();
        idle();
        consume_ext("oor_rd");
        eng_v = 1; eng_w = 0; eng_addr = 'hA0;
        at_neg();
        checks++;
        if ({eng_ready, spm_v} !== 2'b10) begin
            errors++; $display("FAIL oor_eng got=%b exp=10", {eng_ready, spm_v});
        end
        eng_q.push_back('0);
        tick();
        eng_addr = 'h98;
        at_neg();
        eng_q.push_back(ref_mem[19]);
        tick();
        idle();
        at_neg();
        tick();
    endtask

    task automatic test_fairness();
        eng_v = 1; eng_w = 0; eng_addr = 'h08; eng_lock = 0;
        ext_v = 1; ext_w = 1; ext_addr = 'h18;
        for (int i = 1; i <= 8; i++) begin
            ext_data = 64'hF000 + 64'(i);
            at_neg();
            checks++;
            if ({eng_ready, ext_ready} !== {FAIR_EN && (i == 5), !(FAIR_EN && (i == 5))}) begin
                errors++;
                $display("FAIL fair_cycle%0d got=%b exp=%b", i, {eng_ready, ext_ready},
                         {FAIR_EN && (i == 5), !(FAIR_EN && (i == 5))});
            end
            if (ext_ready) ref_mem[3] = ext_data;
            if (eng_ready) eng_q.push_back(ref_mem[1]);
            tick();
        end
        idle();
        ext_v = 1; ext_w = 0; ext_addr = 'h18;
        at_neg();
        checks++;
        if (ext_ready !== 1'b1) begin
            errors++; $display("FAIL fair_rdback got=%b exp=1", ext_ready);
        end
        ext_q.push_back('{d: ref_mem[3], e: 1'b0});
        tick();
        idle();
        consume_ext("fair_rd");
    endtask

    task automatic test_reset_mid();
        // In-flight read.
        ext_v = 1; ext_w = 0; ext_addr = 'h10;
        at_neg();
        tick();
        idle();
        #1 reset = 1;
        #1;
        checks++;
        if ({ext_ready, eng_ready, spm_v, spm_w, ext_rdata_v, eng_rdata_v, ext_err} !== 7'b0) begin
            errors++;
            $display("FAIL rst_async got=%b exp=0000000",
                     {ext_ready, eng_ready, spm_v, spm_w, ext_rdata_v, eng_rdata_v, ext_err});
        end
        tick();
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            at_neg();
            checks++;
            if (ext_rdata_v !== 1'b0) begin
                errors++; $display("FAIL rst_inflight%0d got=%b exp=0", i, ext_rdata_v);
            end
            tick();
        end
        // Buffered, unconsumed read.
        ext_v = 1; ext_w = 0; ext_addr = 'h10;
        at_neg();
        tick();
        idle();
        tick();
        at_neg();
        checks++;
        if (ext_rdata_v !== 1'b1) begin
            errors++; $display("FAIL rst_prefill got=%b exp=1", ext_rdata_v);
        end
        #1 reset = 1;
        #1;
        checks++;
        if (ext_rdata_v !== 1'b0) begin
            errors++; $display("FAIL rst_buf_drop got=%b exp=0", ext_rdata_v);
        end
        tick();
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            checks++;
            if (ext_rdata_v !== 1'b0) begin
                errors++; $display("FAIL rst_buf_after%0d got=%b exp=0", i, ext_rdata_v);
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; ext_yumi = 0;
        ext_addr = '0; ext_data = '0; eng_addr = '0; eng_data = '0;
        idle();
        for (int i = 0; i < ELS; i++) begin
            ref_mem[i] = '0;
            mem[i]     = '0;
        end
        test_reset();
        test_ext_wr_rd();
        test_lock();
        test_backpressure();
        test_eng_read();
        test_range();
        test_fairness();
        test_reset_mid();
        checks++;
        if (ext_q.size() != 0 || eng_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d/%0d exp=0/0", ext_q.size(), eng_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
